// File: rtl/stump_loader_pkg.sv
// Shared types and defaults for the Stump loader/sequencer.
// No logic; latency and backpressure are not applicable.
package stump_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_HALT    = 3'd5,
        ST_TIMEOUT = 3'd6
    } state_e;

    localparam logic [15:0] HALT_ADDR_DEF = 16'hFFFF;
    localparam int unsigned RUN_LIMIT_DEF = 200;
    // Image byte order: first byte of each pair is the high byte.
    localparam bit          BYTE_HI_FIRST = 1'b1;

endpackage

// File: rtl/stump_word_pack.sv
// Byte-to-word assembler: word_valid_o fires combinationally on the completing byte; word/last are registered.
// Latency: the word is on word_o the cycle after word_valid_o; stalls freely with accept_i (no backpressure of its own).
module stump_word_pack
    import stump_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [15:0] word_o,
    output logic        word_valid_o,
    output logic        word_last_o
);

    logic       phase_q;
    logic [7:0] first_q;
    logic [7:0] second_q;
    logic       last_q;

    assign word_valid_o = accept_i && (phase_q || last_i);
    assign word_last_o  = last_q;
    assign word_o       = BYTE_HI_FIRST ? {first_q, second_q} : {second_q, first_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 1'b0;
            first_q  <= 8'h00;
            second_q <= 8'h00;
            last_q   <= 1'b0;
        end else if (clr_i) begin
            phase_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept_i) begin
            last_q <= last_i;
            if (!phase_q) begin
                first_q <= byte_i;
                // A final byte arriving alone is padded with a zero partner.
                if (last_i) begin
                    second_q <= 8'h00;
                end
                phase_q <= !last_i;
            end else begin
                second_q <= byte_i;
                phase_q  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stump_loader_ctrl.sv
// Stump sequencer: loads an image while the CPU is in reset, releases it, then watches for halt/timeout.
// One word per 3 cycles max load rate via ld_ready; LOADER_CHECKSUM_EN adds load_sum/sum_valid outputs.
module stump_loader_ctrl
    import stump_loader_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE  = 16'h0000,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [15:0] HALT_ADDR  = HALT_ADDR_DEF,
    parameter int unsigned RUN_LIMIT  = RUN_LIMIT_DEF,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_start,
    input  logic [7:0]  ld_data,
    input  logic        ld_valid,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_rst,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_mem_wen,
    input  logic        cpu_mem_ren,
    output logic [15:0] cpu_data_in,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  state_o,
    output logic        halted,
    output logic        timeout,
    output logic        load_ovf,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0] load_sum,
    output logic        sum_valid,
`endif
    output logic [31:0] run_cycles
);

    localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [31:0] RUN_LAST = 32'(RUN_LIMIT - 1);

    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic [31:0] run_q, run_d;
    logic        halted_q, halted_d;
    logic        timeout_q, timeout_d;
    logic        ovf_q, ovf_d;
    logic        start_load;
    logic        accept;
    logic [15:0] word;
    logic        word_valid;
    logic        word_last;
    logic [15:0] ptr_off;
    logic        ovf_now;

    assign accept  = ld_valid && (state_q == ST_LOAD);
    assign ptr_off = ptr_q - LOAD_BASE;
    assign ovf_now = {16'h0000, ptr_off} >= MEM_WORDS;

    stump_word_pack u_pack (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_load),
        .accept_i     (accept),
        .byte_i       (ld_data),
        .last_i       (ld_last),
        .word_o       (word),
        .word_valid_o (word_valid),
        .word_last_o  (word_last)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rcnt_d      = rcnt_q;
        run_d       = run_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        ovf_d       = ovf_q;
        start_load  = 1'b0;
        ld_ready    = 1'b0;
        cpu_rst     = 1'b1;
        cpu_data_in = 16'h0000;
        mem_address = 16'h0000;
        mem_wdata   = 16'h0000;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT, ST_TIMEOUT: begin
                start_load = ld_start;
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_address = ptr_q;
                mem_wdata   = word;
                mem_wen     = !ovf_now;
                ovf_d       = ovf_q || ovf_now;
                ptr_d       = ptr_q + 16'd1;
                rcnt_d      = 8'd0;
                state_d     = word_last ? ST_RELEASE : ST_LOAD;
            end
            ST_RELEASE: begin
                if (rcnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                cpu_rst     = 1'b0;
                mem_address = cpu_address;
                mem_wdata   = cpu_data_out;
                mem_wen     = cpu_mem_wen;
                mem_ren     = cpu_mem_ren;
                cpu_data_in = mem_rdata;
                run_d       = run_q + 32'd1;
                // Abort beats halt beats the run limit.
                if (ld_start) begin
                    start_load = 1'b1;
                end else if (cpu_mem_wen && cpu_address == HALT_ADDR) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (run_q == RUN_LAST) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_load) begin
            state_d   = ST_LOAD;
            ptr_d     = LOAD_BASE;
            run_d     = 32'd0;
            halted_d  = 1'b0;
            timeout_d = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= LOAD_BASE;
            rcnt_q    <= 8'd0;
            run_q     <= 32'd0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rcnt_q    <= rcnt_d;
            run_q     <= run_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign state_o    = state_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign load_ovf   = ovf_q;
    assign run_cycles = run_q;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q;
    logic        sum_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= 16'h0000;
            sum_vld_q <= 1'b0;
        end else if (start_load) begin
            sum_q     <= 16'h0000;
            sum_vld_q <= 1'b0;
        end else if (state_q == ST_WRITE) begin
            if (!ovf_now) begin
                sum_q <= sum_q + word;
            end
            if (word_last) begin
                sum_vld_q <= 1'b1;
            end
        end
    end

    assign load_sum  = sum_q;
    assign sum_valid = sum_vld_q;
`endif

endmodule

// File: tb/tb_stump_loader_ctrl.sv
// Self-checking bench for stump_loader_ctrl: bench-owned program memory, image/word model, emulated CPU traffic.
module tb_stump_loader_ctrl;

    localparam int          MW = 16;
    localparam logic [15:0] LB = 16'h0000;
    localparam logic [2:0]  S_IDLE = 3'd0, S_LOAD = 3'd1, S_WRITE = 3'd2, S_REL = 3'd3,
                            S_RUN = 3'd4, S_HALT = 3'd5, S_TMO = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_start = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_rst;
    logic [15:0] cpu_address = 16'h0000;
    logic [15:0] cpu_data_out = 16'h0000;
    logic        cpu_mem_wen = 1'b0;
    logic        cpu_mem_ren = 1'b0;
    logic [15:0] cpu_data_in;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [15:0] mem_rdata;
    logic [2:0]  state_o;
    logic        halted;
    logic        timeout;
    logic        load_ovf;
    logic [31:0] run_cycles;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] wlog_a[$];
    logic [15:0] wlog_d[$];
    logic [7:0]  img[$];
    logic [15:0] ref_mem[int];
    int          ref_addrs[$];

    stump_loader_ctrl #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_last(ld_last), .ld_ready(ld_ready), .cpu_rst(cpu_rst), .cpu_address(cpu_address),
        .cpu_data_out(cpu_data_out), .cpu_mem_wen(cpu_mem_wen), .cpu_mem_ren(cpu_mem_ren),
        .cpu_data_in(cpu_data_in), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .state_o(state_o),
        .halted(halted), .timeout(timeout), .load_ovf(load_ovf), .run_cycles(run_cycles)
    );

    initial forever #5 clk = ~clk;

    assign mem_rdata = mem[mem_address];

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_address] <= mem_wdata;
            wlog_a.push_back(mem_address);
            wlog_d.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // mode 0: always valid; 1: random valid; 2: 5 idle cycles mid-word then valid every other cycle.
    task automatic load_bytes(input int mode);
        int  i = 0;
        int  cyc = 0;
        int  lowc = 0;
        bit  tog = 1'b0;
        bit  v;
        while (i < img.size() && cyc < 2000) begin
            @(negedge clk);
            case (mode)
                0: v = 1'b1;
                1: v = 1'($urandom_range(0, 1));
                default: begin
                    if (i == 1 && lowc < 5) begin
                        v = 1'b0;
                        lowc++;
                    end else if (i >= 1) begin
                        v = tog;
                        tog = !tog;
                    end else begin
                        v = 1'b1;
                    end
                end
            endcase
            ld_valid = v;
            ld_data  = img[i];
            ld_last  = (i == img.size() - 1);
            #1;
            if (v && ld_ready) i++;
            cyc++;
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("load_done", i, img.size());
    endtask

    task automatic to_run(output int rel);
        int n = 0;
        rel = 0;
        while (state_o != S_RUN && n < 40) begin
            @(negedge clk);
            if (state_o == S_REL) begin
                rel++;
                chk("rel_cpu_rst", cpu_rst, 1'b1);
            end
            n++;
        end
        chk("reach_run", state_o, S_RUN);
        chk("run_cpu_rst", cpu_rst, 1'b0);
    endtask

    // Model: bytes pair up high-first, an odd tail is zero-padded, words past MW are dropped.
    task automatic check_image();
        int nw = (img.size() + 1) / 2;
        int nexp = (nw > MW) ? MW : nw;
        logic [15:0] w;
        chk("wr_count", wlog_a.size(), nexp);
        ref_mem.delete();
        ref_addrs.delete();
        for (int k = 0; k < nexp && k < wlog_a.size(); k++) begin
            w[15:8] = img[2 * k];
            w[7:0]  = (2 * k + 1 < img.size()) ? img[2 * k + 1] : 8'h00;
            chk("wr_addr", wlog_a[k], 32'(LB) + k);
            chk("wr_data", wlog_d[k], w);
            ref_mem[int'(LB) + k] = w;
            ref_addrs.push_back(int'(LB) + k);
        end
        chk("load_ovf", load_ovf, nw > MW);
    endtask

    task automatic run_cpu(input int halt_at, input int abort_at, input int budget, output int ran);
        int c = 0;
        int op;
        int a;
        while (state_o == S_RUN && c < budget) begin
            chk("run_cycles_live", run_cycles, c);
            ld_start    = (c == abort_at);
            cpu_mem_wen = 1'b0;
            cpu_mem_ren = 1'b0;
            op = 0;
            if (c == halt_at) begin
                cpu_mem_wen  = 1'b1;
                cpu_address  = 16'hFFFF;
                cpu_data_out = 16'h0007;
            end else begin
                op = $urandom_range(0, 2);
                if (op == 1) begin
                    a = ref_addrs[$urandom_range(0, ref_addrs.size() - 1)];
                    cpu_mem_ren = 1'b1;
                    cpu_address = 16'(a);
                end else if (op == 2) begin
                    a = 16'h0100 + $urandom_range(0, 15);
                    cpu_mem_wen  = 1'b1;
                    cpu_address  = 16'(a);
                    cpu_data_out = 16'($urandom);
                    if (!ref_mem.exists(a)) ref_addrs.push_back(a);
                    ref_mem[a] = cpu_data_out;
                end
            end
            #1;
            chk("pass_addr", mem_address, cpu_address);
            chk("pass_ctl", {mem_wdata, mem_wen, mem_ren}, {cpu_data_out, cpu_mem_wen, cpu_mem_ren});
            if (op == 1) chk("rd_data", cpu_data_in, ref_mem[int'(cpu_address)]);
            @(negedge clk);
            c++;
        end
        ld_start    = 1'b0;
        cpu_mem_wen = 1'b0;
        cpu_mem_ren = 1'b0;
        ran = c;
    endtask

    initial begin
        int rel;
        int ran;
        int nlog;

        // Reset values, with CPU requests present that must not leak through.
        cpu_mem_wen = 1'b1;
        cpu_mem_ren = 1'b1;
        cpu_address = 16'h1234;
        cpu_data_out = 16'hBEEF;
        #3;
        chk("rst_state", state_o, S_IDLE);
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_mem", {mem_address, mem_wdata, mem_wen, mem_ren}, 32'h0);
        chk("rst_cpu_din", cpu_data_in, 16'h0000);
        chk("rst_flags", {halted, timeout, load_ovf}, 3'b000);
        chk("rst_run_cycles", run_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cpu_mem_wen = 1'b0;
        cpu_mem_ren = 1'b0;
        ld_valid = 1'b1;
        @(negedge clk);
        chk("idle_hold", state_o, S_IDLE);
        chk("idle_no_ready", ld_ready, 1'b0);
        ld_valid = 1'b0;

        // 4-byte image, halt at run cycle 10.
        clear_log();
        pulse_start();
        chk("start_state", state_o, S_LOAD);
        chk("start_ready", ld_ready, 1'b1);
        img = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        load_bytes(0);
        to_run(rel);
        chk("release_len", rel, 2);
        chk("run_halted0", halted, 1'b0);
        check_image();
        run_cpu(10, -1, 300, ran);
        chk("halt_ran", ran, 11);
        chk("halt_state", state_o, S_HALT);
        chk("halt_flag", {halted, timeout}, 2'b10);
        chk("halt_cpu_rst", cpu_rst, 1'b1);
        chk("halt_run_cycles", run_cycles, 32'd11);
        chk("halt_write_addr", wlog_a[$], 16'hFFFF);
        chk("halt_write_data", wlog_d[$], 16'h0007);
        cpu_mem_wen = 1'b1;
        cpu_mem_ren = 1'b1;
        cpu_address = 16'h0001;
        #1;
        chk("halt_mem_idle", {mem_wen, mem_ren, mem_address}, 18'h0);
        chk("halt_cpu_din", cpu_data_in, 16'h0000);
        cpu_mem_wen = 1'b0;
        cpu_mem_ren = 1'b0;

        // 3-byte image with random gaps, never halts.
        clear_log();
        pulse_start();
        chk("reload_flags", {halted, run_cycles[7:0]}, 9'h0);
        img = '{8'h12, 8'h34, 8'h56};
        load_bytes(1);
        to_run(rel);
        check_image();
        run_cpu(-1, -1, 300, ran);
        chk("tmo_ran", ran, 200);
        chk("tmo_state", state_o, S_TMO);
        chk("tmo_flag", {halted, timeout}, 2'b01);
        chk("tmo_cpu_rst", cpu_rst, 1'b1);
        chk("tmo_run_cycles", run_cycles, 32'd200);

        // Stalled valid mid-word, then abort at run cycle 50.
        clear_log();
        pulse_start();
        img.delete();
        for (int k = 0; k < 8; k++) img.push_back(8'($urandom));
        load_bytes(2);
        to_run(rel);
        check_image();
        run_cpu(-1, 50, 300, ran);
        chk("abort_ran", ran, 51);
        chk("abort_state", state_o, S_LOAD);
        chk("abort_cpu_rst", cpu_rst, 1'b1);
        chk("abort_run_cycles", run_cycles, 32'd0);

        // Image longer than MW words: excess dropped, load_ovf set.
        clear_log();
        img.delete();
        for (int k = 0; k < 2 * MW + 4; k++) img.push_back(8'($urandom));
        load_bytes(1);
        to_run(rel);
        check_image();
        run_cpu(-1, 0, 10, ran);
        chk("abort2_ran", ran, 1);
        chk("abort2_state", state_o, S_LOAD);

        // Asynchronous reset while a word is being written.
        clear_log();
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'hA5;
        @(negedge clk);
        ld_data  = 8'h5A;
        @(negedge clk);
        ld_valid = 1'b0;
        chk("pre_rst_write", state_o, S_WRITE);
        chk("pre_rst_wen", mem_wen, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_wen", mem_wen, 1'b0);
        chk("arst_state", state_o, S_IDLE);
        chk("arst_cpu_rst", cpu_rst, 1'b1);
        chk("arst_flags", {halted, timeout, load_ovf, ld_ready}, 4'b0000);
        repeat (2) @(negedge clk);
        nlog = wlog_a.size();
        chk("arst_no_write", nlog, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
